fsm_update_buffered: RTL
========================

# fsm_update_buffered

Parametrised successor to the gated work/result FSM. Every in-flight result is queued in a DEPTH-entry FIFO and drained under back-pressure, so no result, including the final one, is lost while `almfull` is high. The block sits between a compute engine (start/finish/result strobes) and a downstream consumer that signals back-pressure through `almfull`.

## Interface
- `DATA_W`, 32: width of result and output data.
- `DEPTH`, 4: FIFO entries. Power of two, ≥ 2.
- `CNT_W`, $clog2(DEPTH+1): occupancy width (derived; do not override).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a job. Honoured only in IDLE.
- `finish` in 1: end of job. Honoured only in WORK.
- `almfull` in 1: downstream back-pressure. No output is produced while high.
- `result_valid` in 1: intermediate result strobe. Honoured only in WORK.
- `result_data` in DATA_W: intermediate result payload.
- `final_data` in DATA_W: final result payload. Sampled in FINAL.
- `valid` out 1: registered output strobe, one cycle per entry.
- `data` out DATA_W: registered output data. Holds its value when `valid` is low.
- `last` out 1: qualifies `valid`. Marks the final entry of a job.
- `busy` out 1: high when state ≠ IDLE.
- `overflow` out 1: sticky. Set when an intermediate result is dropped; cleared by an accepted `start`.
- `count` out CNT_W: current FIFO occupancy.

## Operation
- States: IDLE, WORK, FINAL, DRAIN.
  - IDLE → WORK on `start`.
  - WORK → FINAL on `finish`.
  - FINAL → DRAIN when the final entry is pushed.
  - DRAIN → IDLE in the cycle the `last`-tagged entry is popped.
- FIFO entries are {tag, DATA_W data}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Pop condition: `!almfull && count != 0`. On pop, registered outputs load: `valid`←1, `data`←head data, `last`←head tag. Otherwise `valid`←0 and `last`←0, and `data` holds.
- Space condition: `count < DEPTH || pop`. A pop frees a slot in the same cycle.
- Intermediate results:
  - In WORK, `result_valid` pushes {0, `result_data`} if space is available.
  - Otherwise the result is dropped and `overflow`←1.
  - `result_valid` together with `finish` in the same cycle: the result is pushed (subject to space) and the state moves to FINAL.
- Final result:
  - In FINAL, {1, `final_data`} is pushed when space is available.
  - Otherwise FINAL stalls. The final entry is never dropped.
- Occupancy: `count` increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- Ignored inputs:
  - `start` outside IDLE.
  - `finish` and `result_valid` outside WORK.
- `busy` and `count` are registered state; `count` reflects the post-edge occupancy.

## Timing
- Reset (`reset_n` low, asynchronous):
  - state = IDLE.
  - `valid` = 0, `last` = 0, `data` = 0, `overflow` = 0, `count` = 0, `busy` = 0.
  - FIFO pointers cleared.
- Reset asserted mid-job discards all queued entries. No `last` is emitted for that job.
- Latency, empty FIFO and `almfull` low: `result_valid` in cycle t → `valid` high in cycle t+2.
- Throughput: one pop per cycle while `almfull` is low.
- `almfull` is evaluated in the same cycle as the pop decision. Raising it in cycle t gives `valid` = 0 in cycle t+1.
- `overflow` is set in the cycle after the dropped push. A `start` accepted in cycle t clears it in cycle t+1.
- Minimum job, all inputs favourable (`start`@0, `finish`@1):
  - WORK@1, FINAL@2, final push@2.
  - Pop@3, `valid` + `last`@4.
  - IDLE from the edge ending cycle 3.
  - Next `start` accepted @4.

## Test plan
- Basic job, DEPTH=4, `almfull` = 0: `start`@0, results 0x11, 0x22 @1–2, `finish`@3, `final_data`=0xAAAAAAAA → `data` 0x11 @3, 0x22 @4, 0xAAAAAAAA @6 with `last`=1; `busy` low @6.
- Back-pressure hold: `almfull` = 1 during 3 results then `finish` → `count` reaches 4, no `valid`. Drop `almfull` → four consecutive `valid` cycles, the 4th with `last`; `overflow` stays 0.
- Overflow: `almfull` = 1, 6 results with DEPTH=4 → 2 dropped, `overflow`=1. `finish` stalls in FINAL (`busy`=1, `count`=4). Release `almfull` → final pushed after the first pop and emitted last. Next `start` clears `overflow`.
- Simultaneous `result_valid` + `finish`, `result_data` 0x55, `final_data` 0x66 → output 0x55 then 0x66 (`last`), in order.
- Wrap-around: 10 back-to-back jobs of 3 results each with random `almfull` → output sequence equals input sequence; exactly one `last` per job.
- Async reset mid-DRAIN with `count`=3 → all outputs 0 immediately, no `last` emitted, `start` after release accepted.

Source files
------------

// File: rtl/fsm_update_buffered.sv
// fsm_update_buffered: job FSM whose intermediate and final results are queued
// in a FIFO and drained to the consumer only while almfull is low.
module fsm_update_buffered #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              finish,
    input  logic              almfull,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result_data,
    input  logic [DATA_W-1:0] final_data,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic              busy,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WORK = 2'd1, FINAL = 2'd2, DRAIN = 2'd3;
    logic [1:0]        state, state_nxt;
    logic [DATA_W:0]   mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W:0]   head;
    logic              pop, space, push_int, push_fin, push, drop;
    assign head     = mem[rd_ptr];
    assign pop      = !almfull && count != '0;
    // a pop in the same cycle frees the slot the push needs
    assign space    = count < CNT_W'(DEPTH) || pop;
    assign push_int = state == WORK && result_valid && space;
    assign drop     = state == WORK && result_valid && !space;
    assign push_fin = state == FINAL && space;
    assign push     = push_int || push_fin;
    assign busy     = state != IDLE;
    assign state_nxt = (state == IDLE && start)                 ? WORK  :
                       (state == WORK && finish)                ? FINAL :
                       push_fin                                 ? DRAIN :
                       (state == DRAIN && pop && head[DATA_W])  ? IDLE  : state;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_fin, push_fin ? final_data : result_data};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            valid    <= pop;
            last     <= pop && head[DATA_W];
            data     <= pop ? head[DATA_W-1:0] : data;
            overflow <= (state == IDLE && start) ? 1'b0 : overflow || drop;
        end
    end
endmodule
